gpio_pattern_sequencer: RTL and testbench

//  Wishbone-programmable sequencer for the user-project GPIO pads (mprj_io).
//  - Firmware loads a table of output words, a step length and output enables.
//  - The block then plays the table onto io_out at a programmable rate, once or looping.
//  - Sits in user_project_wrapper between the Wishbone slave port and io_out/io_oeb.

---
 rtl/gpio_pattern_sequencer.sv | 144 ++++++++++++++
 tb/tb_gpio_pattern_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_pattern_sequencer.sv
// gpio_pattern_sequencer: Wishbone-loaded pattern table played onto mprj_io; optional done IRQ under GPIO_SEQ_IRQ_EN
module gpio_pattern_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int NIO = 32,
  parameter int DEPTH = 16,
  parameter int DIVW = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic [NIO-1:0]  io_out,
  output logic [NIO-1:0]  io_oeb,
  output logic            busy_o,
  output logic            irq_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [31:0] mem [DEPTH];
  logic [NIO-1:0] oeb_n, out_n;
  logic [LW-1:0] len;
  logic [DIVW-1:0] div, cnt, cnt_n;
  logic [IW-1:0] idx, idx_n, tidx, idx_inc;
  logic [11:0] off;
  logic [31:0] rdata, wmask, wdat, oeb_rd;
  logic req, wr, in_base, hit_ctrl, hit_stat, hit_oeb, hit_len, hit_div, hit_tbl;
  logic loop_en, done, start_q, stop_q, last, irq_en_rd;
  assign off = wbs_adr_i[11:0];
  assign in_base = wbs_adr_i[31:12] == BASE_ADDR[31:12];
  assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr = req & wbs_we_i;
  assign hit_ctrl = in_base & (off == 12'h000);
  assign hit_stat = in_base & (off == 12'h004);
  assign hit_oeb = in_base & (off == 12'h008);
  assign hit_len = in_base & (off == 12'h00C);
  assign hit_div = in_base & (off == 12'h010);
  assign hit_tbl = in_base & (off[11:8] == 4'h1) & (off[1:0] == 2'b00) & (32'(off[7:2]) < DEPTH);
  assign tidx = off[2 +: IW];
  assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wdat = (rdata & ~wmask) | (wbs_dat_i & wmask);
  assign busy_o = (state == LOAD) | (state == HOLD);
  assign idx_inc = idx + 1'b1;
  assign last = LW'(idx) + LW'(1) >= len;
  assign rdata = hit_ctrl ? {28'd0, irq_en_rd, loop_en, 2'b00} :
                 hit_stat ? {16'd0, 8'(idx), 6'd0, done, busy_o} :
                 hit_oeb  ? oeb_rd :
                 hit_len  ? 32'(len) :
                 hit_div  ? 32'(div) :
                 hit_tbl  ? mem[tidx] : '0;
`ifdef GPIO_SEQ_IRQ_EN
  logic irq_en;
  // interrupt enable bit of CTRL
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) irq_en <= 1'b0;
    else if (wr & hit_ctrl) irq_en <= wdat[3];
  assign irq_en_rd = irq_en;
  assign irq_o = done & irq_en;
`else
  assign irq_en_rd = 1'b0;
  assign irq_o = 1'b0;
`endif
  // OEB read alignment and byte-lane merge; pads above bit 31 stay disabled
  always_comb begin
    oeb_rd = '0;
    oeb_n = io_oeb;
    for (int i = 0; i < 32; i++) if (i < NIO) oeb_rd[i] = io_oeb[i % NIO];
    for (int i = 0; i < NIO; i++) if (i < 32) oeb_n[i] = wdat[i % 32];
  end
  // bus handshake, control pulses and programmable registers
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      start_q <= 1'b0;
      stop_q <= 1'b0;
      loop_en <= 1'b0;
      done <= 1'b0;
      io_oeb <= '1;
      len <= '0;
      div <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req & ~wbs_we_i) ? rdata : '0;
      start_q <= wr & hit_ctrl & wdat[0];
      stop_q <= wr & hit_ctrl & wdat[1];
      done <= (state == DONE) | (done & ~(wr & hit_stat & wmask[1] & wbs_dat_i[1]));
      if (wr & hit_ctrl) loop_en <= wdat[2];
      if (wr & hit_oeb) io_oeb <= oeb_n;
      if (wr & hit_len) len <= (wdat > 32'(DEPTH)) ? LW'(DEPTH) : wdat[LW-1:0];
      if (wr & hit_div) div <= wdat[DIVW-1:0];
    end
  // pattern table, not reset
  always_ff @(posedge wb_clk_i)
    if (wr & hit_tbl) mem[tidx] <= wdat;
  // sequencer state register
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      io_out <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      io_out <= out_n;
    end
  // next entry fetch merges into the final hold cycle so entries play back-to-back
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    out_n = io_out;
    if (stop_q) state_n = IDLE;
    else if (start_q && len != '0) begin
      state_n = LOAD;
      idx_n = '0;
    end else
      case (state)
        LOAD: begin
          out_n = mem[idx][NIO-1:0];
          cnt_n = div;
          state_n = HOLD;
        end
        HOLD:
          if (cnt != '0) cnt_n = cnt - 1'b1;
          else if (!last || loop_en) begin
            idx_n = last ? '0 : idx_inc;
            out_n = mem[last ? '0 : idx_inc][NIO-1:0];
            cnt_n = div;
          end else state_n = DONE;
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// tb_gpio_pattern_sequencer: register vectors, directed playback cases and random runs against a trace model
module tb_gpio_pattern_sequencer;
  localparam logic [31:0] B = 32'h3000_0000;
  localparam int DEPTH = 16;
`ifdef GPIO_SEQ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0] wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic wbs_ack_o, busy_o, irq_o;
  logic [31:0] wbs_dat_o, io_out, io_oeb;
  int vectors = 0, miscompares = 0;
  logic [31:0] pat [DEPTH];
  bit irq_en = 1'b0;

  gpio_pattern_sequencer dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .io_out(io_out), .io_oeb(io_oeb),
    .busy_o(busy_o), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    int n = 0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    do begin
      tick();
      n++;
    end while (!wbs_ack_o && n < 8);
    if (!wbs_ack_o) chk("ack_timeout", 32'(wbs_ack_o), 32'd1);
    rd = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
    logic [31:0] d;
    wb_xfer(1'b1, adr, dat, sel, d);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, '0, 4'hF, d);
  endtask

  task automatic load_pat(input int len);
    for (int i = 0; i < len; i++) wb_write(B + 32'h100 + 32'(4 * i), pat[i]);
  endtask

  // Expected trace: entry k/(div+1), wrapping when looping, parking on the last entry otherwise
  task automatic play(input int len, input int div, input bit lp);
    int n, kmax;
    logic [31:0] eo, frozen, d;
    n = len * (div + 1);
    kmax = lp ? 3 * n + 2 : n;
    wb_write(B + 32'h0C, 32'(len));
    wb_write(B + 32'h10, 32'(div));
    wb_write(B, 32'h1 | (32'(lp) << 2) | (32'(irq_en) << 3));
    tick();
    chk("busy_load", 32'(busy_o), 32'd1);
    tick();
    for (int k = 0; k <= kmax; k++) begin
      eo = lp ? pat[(k / (div + 1)) % len] : (k < n ? pat[k / (div + 1)] : pat[len - 1]);
      chk($sformatf("io_out_k%0d", k), io_out, eo);
      chk($sformatf("busy_k%0d", k), 32'(busy_o), 32'(lp || k < n));
      tick();
    end
    if (lp) begin
      wb_write(B, 32'h2);
      frozen = io_out;
      tick();
      chk("stop_busy", 32'(busy_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
        chk("stop_frozen", io_out, frozen);
        tick();
      end
      wb_read(B + 32'h04, d);
      chk("stop_status", d & 32'h3, 32'h0);
    end else begin
      wb_read(B + 32'h04, d);
      chk("done_status", d & 32'h3, 32'h2);
      chk("irq_done", 32'(irq_o), 32'(IRQ_ON & irq_en));
      wb_write(B + 32'h04, 32'h2);
      chk("irq_clr", 32'(irq_o), 32'd0);
      wb_read(B + 32'h04, d);
      chk("status_clr", d & 32'h3, 32'h0);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [17];

  initial begin
    logic [31:0] d, held;
    vt[0]  = '{B + 32'h08, 32'hA5A5_5A5A, 4'hF, 32'hA5A5_5A5A};
    vt[1]  = '{B + 32'h08, 32'hFFFF_FFFF, 4'h1, 32'hA5A5_5AFF};
    vt[2]  = '{B + 32'h0C, 32'h3, 4'hF, 32'h3};
    vt[3]  = '{B + 32'h0C, 32'hFF, 4'hF, 32'd16};
    vt[4]  = '{B + 32'h0C, 32'h11, 4'hF, 32'd16};
    vt[5]  = '{B + 32'h0C, 32'h10, 4'hF, 32'd16};
    vt[6]  = '{B + 32'h0C, 32'h0, 4'hF, 32'h0};
    vt[7]  = '{B + 32'h10, 32'h1234, 4'hF, 32'h1234};
    vt[8]  = '{B + 32'h10, 32'hFFFF_FFFF, 4'h2, 32'hFF34};
    vt[9]  = '{B + 32'h13C, 32'h0BAD_F00D, 4'hF, 32'h0BAD_F00D};
    vt[10] = '{B + 32'h13C, 32'h1234_5678, 4'hC, 32'h1234_F00D};
    vt[11] = '{32'h3000_2000, 32'h55, 4'hF, 32'h0};
    vt[12] = '{B + 32'h20, 32'h55, 4'hF, 32'h0};
    vt[13] = '{B + 32'h140, 32'h55, 4'hF, 32'h0};
    vt[14] = '{B, 32'hC, 4'hF, IRQ_ON ? 32'hC : 32'h4};
    vt[15] = '{B, 32'h0, 4'hF, 32'h0};
    vt[16] = '{B + 32'h04, 32'hFFFF, 4'hF, 32'h0};
    repeat (3) tick();
    wb_rst_i = 1'b0;
    chk("rst_io_out", io_out, 32'h0);
    chk("rst_io_oeb", io_oeb, 32'hFFFF_FFFF);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    wb_read(B + 32'h04, d);
    chk("rst_status", d, 32'h0);
    for (int i = 0; i < 17; i++) begin
      wb_write(vt[i].adr, vt[i].wd, vt[i].sel);
      wb_read(vt[i].adr, d);
      chk($sformatf("vec%0d", i), d, vt[i].exp);
    end
    chk("oeb_pins", io_oeb, 32'hA5A5_5AFF);
    wb_write(B + 32'h08, 32'h0);
    chk("oeb_zero", io_oeb, 32'h0);
    pat[0] = 32'h1234_5678;
    load_pat(1);
    irq_en = 1'b1;
    play(1, 0, 1'b0);
    irq_en = 1'b0;
    for (int i = 0; i < 4; i++) pat[i] = 32'(i + 1);
    load_pat(4);
    play(4, 2, 1'b0);
    play(4, 2, 1'b1);
    for (int r = 0; r < 6; r++) begin
      int len, div;
      len = (r == 0) ? DEPTH : int'($urandom_range(1, 8));
      div = int'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) pat[i] = $urandom;
      load_pat(len);
      play(len, div, 1'($urandom_range(0, 1)));
    end
    wb_write(B + 32'h0C, 32'h0);
    held = io_out;
    wb_write(B, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("len0_busy", 32'(busy_o), 32'd0);
      chk("len0_out", io_out, held);
      tick();
    end
    for (int i = 0; i < 4; i++) pat[i] = 32'hF0 + 32'(i);
    load_pat(4);
    wb_write(B + 32'h0C, 32'h4);
    wb_write(B + 32'h10, 32'h2);
    wb_write(B, 32'h5);
    repeat (5) tick();
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    chk("mid_rst_out", io_out, 32'h0);
    chk("mid_rst_oeb", io_oeb, 32'hFFFF_FFFF);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    wb_read(B + 32'h04, d);
    chk("mid_rst_status", d, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
